// File: rtl/bus_pkg.sv
// Shared types and constants for the data bus master.
package bus_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWr,
        StRmwRd,
        StRmwWr,
        StDone
    } t_bus_state;

    localparam logic [3:0] BYTE_ALL  = 4'b1111;
    localparam logic [3:0] BYTE_NONE = 4'b0000;

endpackage

// File: rtl/byte_merge.sv
// Per-byte merge of a new word into an old word under a byte mask.
module byte_merge
    import bus_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_word,
    input  logic [3:0]  mask,
    output logic [31:0] merged_word
);

    // Byte i comes from new_word when mask[i] is set, otherwise from old_word.
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                merged_word[8*i +: 8] = new_word[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_bus_master.sv
// Avalon-style data bus master for single word-aligned loads and stores.
// Partial stores use byte enables or an internal read-modify-write.
module data_bus_master
    import bus_pkg::*;
#(
    parameter bit USE_BYTEENABLE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        busy,
    output logic        rsp_done,
    output logic [31:0] rsp_rdata,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    t_bus_state  state_q, state_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] address_q, address_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  be_q, be_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] merged_word;

    // Address bits [1:0] never reach the bus.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];

    // Merges the word returned by the RMW read with the latched store bytes.
    byte_merge u_byte_merge (
        .old_word    (avm_readdata),
        .new_word    (wdata_q),
        .mask        (mask_q),
        .merged_word (merged_word)
    );

    // Next-state, request latching and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        rdata_d     = rdata_q;
        address_d   = address_q;
        writedata_d = writedata_q;
        be_d        = be_q;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    address_d = {req_addr[31:2], 2'b00};
                    wdata_d   = req_wdata;
                    mask_d    = req_mask;
                    if (!req_write) begin
                        state_d = StRd;
                        be_d    = BYTE_ALL;
                    end else if (req_mask == BYTE_NONE) begin
                        state_d = StDone;
                    end else if (req_mask == BYTE_ALL || USE_BYTEENABLE) begin
                        state_d     = StWr;
                        be_d        = req_mask;
                        writedata_d = req_wdata;
                    end else begin
                        state_d = StRmwRd;
                        be_d    = BYTE_ALL;
                    end
                end
            end
            StRd: begin
                if (!avm_waitrequest) begin
                    rdata_d = avm_readdata;
                    state_d = StDone;
                end
            end
            StWr: begin
                if (!avm_waitrequest) begin
                    state_d = StDone;
                end
            end
            StRmwRd: begin
                // The write-data register doubles as the merge register.
                if (!avm_waitrequest) begin
                    writedata_d = merged_word;
                    state_d     = StRmwWr;
                end
            end
            StRmwWr: begin
                if (!avm_waitrequest) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Strobes and status are decoded from the next state so they are registered.
        read_d  = (state_d == StRd) || (state_d == StRmwRd);
        write_d = (state_d == StWr) || (state_d == StRmwWr);
        busy_d  = (state_d != StIdle);
        done_d  = (state_d == StDone);
    end

    // State and output registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wdata_q     <= '0;
            mask_q      <= BYTE_NONE;
            rdata_q     <= '0;
            address_q   <= '0;
            writedata_q <= '0;
            be_q        <= BYTE_NONE;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            rdata_q     <= rdata_d;
            address_q   <= address_d;
            writedata_q <= writedata_d;
            be_q        <= be_d;
            read_q      <= read_d;
            write_q     <= write_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy           = busy_q;
    assign rsp_done       = done_q;
    assign rsp_rdata      = rdata_q;
    assign avm_address    = address_q;
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_writedata  = writedata_q;
    assign avm_byteenable = be_q;

endmodule

// File: tb/tb_data_bus_master.sv
// Directed bench for data_bus_master in both byte-enable and read-modify-write modes.
module tb_data_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_be, req_valid_rm;
    logic        req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_mask;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    logic        be_busy, be_done, be_rd, be_wr;
    logic [31:0] be_rdata, be_addr, be_wdata;
    logic [3:0]  be_be;
    logic        rm_busy, rm_done, rm_rd, rm_wr;
    logic [31:0] rm_rdata, rm_addr, rm_wdata;
    logic [3:0]  rm_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_bus_master #(.USE_BYTEENABLE(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_be), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .busy(be_busy), .rsp_done(be_done), .rsp_rdata(be_rdata),
        .avm_address(be_addr), .avm_read(be_rd), .avm_write(be_wr),
        .avm_writedata(be_wdata), .avm_byteenable(be_be),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    data_bus_master #(.USE_BYTEENABLE(1'b0)) dut_rm (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_rm), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .busy(rm_busy), .rsp_done(rm_done), .rsp_rdata(rm_rdata),
        .avm_address(rm_addr), .avm_read(rm_rd), .avm_write(rm_wr),
        .avm_writedata(rm_wdata), .avm_byteenable(rm_be),
        .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] slave_rdata;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_rsp_rdata;
        int          done_cyc;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // Zero-wait transactions on the byte-enable instance.
        vecs[0] = '{1'b0, 32'h0000_1007, 32'h0, 4'h0, 32'hDEAD_BEEF,
                    1'b1, 1'b0, 32'h0000_1004, 4'hF, 32'hDEAD_BEEF, 2};
        vecs[1] = '{1'b1, 32'h0000_2000, 32'h1122_3344, 4'hF, 32'h0,
                    1'b0, 1'b1, 32'h0000_2000, 4'hF, 32'hDEAD_BEEF, 2};
        vecs[2] = '{1'b1, 32'h0000_3002, 32'h00AB_0000, 4'b0100, 32'h0,
                    1'b0, 1'b1, 32'h0000_3000, 4'b0100, 32'hDEAD_BEEF, 2};
        vecs[3] = '{1'b1, 32'h0000_3100, 32'hFFFF_FFFF, 4'h0, 32'h0,
                    1'b0, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF, 1};
        vecs[4] = '{1'b0, 32'h0000_4000, 32'h0, 4'hF, 32'hCAFE_F00D,
                    1'b1, 1'b0, 32'h0000_4000, 4'hF, 32'hCAFE_F00D, 2};
        vecs[5] = '{1'b1, 32'h0000_500E, 32'hBEEF_0000, 4'b1100, 32'h0,
                    1'b0, 1'b1, 32'h0000_500C, 4'b1100, 32'hCAFE_F00D, 2};

        rst_n = 1'b0;
        req_valid_be = 1'b0;
        req_valid_rm = 1'b0;
        req_write = 1'b0;
        req_addr = '0;
        req_wdata = '0;
        req_mask = '0;
        avm_readdata = '0;
        avm_waitrequest = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset busy", {31'b0, be_busy}, 32'd0);
        chk("reset done", {31'b0, be_done}, 32'd0);
        chk("reset strobes", {30'b0, be_rd, be_wr}, 32'd0);
        chk("reset rdata", be_rdata, 32'd0);
        chk("reset addr", be_addr, 32'd0);
        chk("reset wdata", be_wdata, 32'd0);
        chk("reset be", {28'b0, be_be}, 32'd0);
        chk("reset rmw strobes", {30'b0, rm_rd, rm_wr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            req_write = vecs[v].wr;
            req_addr = vecs[v].addr;
            req_wdata = vecs[v].wdata;
            req_mask = vecs[v].mask;
            avm_readdata = vecs[v].slave_rdata;
            req_valid_be = 1'b1;
            @(negedge clk);
            req_valid_be = 1'b0;
            for (int c = 1; c <= vecs[v].done_cyc + 1; c++) begin
                if (c < vecs[v].done_cyc) begin
                    chk($sformatf("v%0d c%0d read", v, c), {31'b0, be_rd}, {31'b0, vecs[v].exp_rd});
                    chk($sformatf("v%0d c%0d write", v, c), {31'b0, be_wr}, {31'b0, vecs[v].exp_wr});
                    chk($sformatf("v%0d c%0d addr", v, c), be_addr, vecs[v].exp_addr);
                    chk($sformatf("v%0d c%0d be", v, c), {28'b0, be_be}, {28'b0, vecs[v].exp_be});
                    if (vecs[v].exp_wr)
                        chk($sformatf("v%0d c%0d wdata", v, c), be_wdata, vecs[v].wdata);
                end else begin
                    chk($sformatf("v%0d c%0d idle strobes", v, c), {30'b0, be_rd, be_wr}, 32'd0);
                end
                chk($sformatf("v%0d c%0d done", v, c), {31'b0, be_done},
                    {31'b0, (c == vecs[v].done_cyc)});
                chk($sformatf("v%0d c%0d busy", v, c), {31'b0, be_busy},
                    {31'b0, (c <= vecs[v].done_cyc)});
                @(negedge clk);
            end
            chk($sformatf("v%0d rsp_rdata", v), be_rdata, vecs[v].exp_rsp_rdata);
        end

        // Load with three wait states.
        req_write = 1'b0;
        req_addr = 32'h0000_2009;
        req_valid_be = 1'b1;
        avm_waitrequest = 1'b1;
        avm_readdata = 32'h1111_1111;
        @(negedge clk);
        req_valid_be = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin
                avm_waitrequest = 1'b0;
                avm_readdata = 32'h0BAD_F00D;
            end
            chk($sformatf("wait c%0d read", c), {31'b0, be_rd}, 32'd1);
            chk($sformatf("wait c%0d addr", c), be_addr, 32'h0000_2008);
            chk($sformatf("wait c%0d done", c), {31'b0, be_done}, 32'd0);
            @(negedge clk);
        end
        chk("wait c5 done", {31'b0, be_done}, 32'd1);
        chk("wait c5 rdata", be_rdata, 32'h0BAD_F00D);
        chk("wait c5 read", {31'b0, be_rd}, 32'd0);
        @(negedge clk);
        chk("wait c6 busy", {31'b0, be_busy}, 32'd0);

        // Read-modify-write partial store.
        req_write = 1'b1;
        req_addr = 32'h0000_6001;
        req_wdata = 32'h0000_1234;
        req_mask = 4'b0011;
        avm_readdata = 32'h5566_7788;
        req_valid_rm = 1'b1;
        @(negedge clk);
        req_valid_rm = 1'b0;
        chk("rmw c1 strobes", {30'b0, rm_rd, rm_wr}, 32'd2);
        chk("rmw c1 addr", rm_addr, 32'h0000_6000);
        chk("rmw c1 be", {28'b0, rm_be}, 32'hF);
        @(negedge clk);
        avm_readdata = 32'hFFFF_FFFF;
        chk("rmw c2 strobes", {30'b0, rm_rd, rm_wr}, 32'd1);
        chk("rmw c2 wdata", rm_wdata, 32'h5566_1234);
        chk("rmw c2 be", {28'b0, rm_be}, 32'hF);
        chk("rmw c2 done", {31'b0, rm_done}, 32'd0);
        @(negedge clk);
        chk("rmw c3 done", {31'b0, rm_done}, 32'd1);
        chk("rmw c3 strobes", {30'b0, rm_rd, rm_wr}, 32'd0);
        chk("rmw rsp_rdata kept", rm_rdata, 32'd0);
        @(negedge clk);
        chk("rmw c4 busy", {31'b0, rm_busy}, 32'd0);

        // Full-word store in RMW mode still uses a single write.
        req_mask = 4'hF;
        req_wdata = 32'hA5A5_5A5A;
        req_valid_rm = 1'b1;
        @(negedge clk);
        req_valid_rm = 1'b0;
        chk("rm full c1 strobes", {30'b0, rm_rd, rm_wr}, 32'd1);
        chk("rm full c1 wdata", rm_wdata, 32'hA5A5_5A5A);
        @(negedge clk);
        chk("rm full c2 done", {31'b0, rm_done}, 32'd1);
        @(negedge clk);

        // Empty-mask store with req_valid held high through DONE.
        req_mask = 4'h0;
        req_valid_be = 1'b1;
        @(negedge clk);
        chk("b2b c1 done", {31'b0, be_done}, 32'd1);
        chk("b2b c1 strobes", {30'b0, be_rd, be_wr}, 32'd0);
        @(negedge clk);
        chk("b2b c2 done", {31'b0, be_done}, 32'd0);
        chk("b2b c2 busy", {31'b0, be_busy}, 32'd0);
        @(negedge clk);
        req_valid_be = 1'b0;
        chk("b2b c3 done", {31'b0, be_done}, 32'd1);
        @(negedge clk);
        chk("b2b c4 done", {31'b0, be_done}, 32'd0);

        // Reset during a stalled RMW write phase.
        req_addr = 32'h0000_7000;
        req_wdata = 32'h0000_00AA;
        req_mask = 4'b0001;
        avm_readdata = 32'h1122_3344;
        req_valid_rm = 1'b1;
        @(negedge clk);
        req_valid_rm = 1'b0;
        @(negedge clk);
        avm_waitrequest = 1'b1;
        chk("rst c2 write", {31'b0, rm_wr}, 32'd1);
        chk("rst c2 wdata", rm_wdata, 32'h1122_33AA);
        @(negedge clk);
        chk("rst c3 write held", {31'b0, rm_wr}, 32'd1);
        chk("rst c3 wdata held", rm_wdata, 32'h1122_33AA);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async write", {31'b0, rm_wr}, 32'd0);
        chk("rst async busy", {31'b0, rm_busy}, 32'd0);
        @(negedge clk);
        avm_waitrequest = 1'b0;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("post rst c%0d done", c), {31'b0, rm_done}, 32'd0);
            chk($sformatf("post rst c%0d busy", c), {31'b0, rm_busy}, 32'd0);
        end
        chk("post rst addr", rm_addr, 32'd0);
        chk("post rst wdata", rm_wdata, 32'd0);
        chk("post rst be", {28'b0, rm_be}, 32'd0);
        chk("post rst strobes", {30'b0, rm_rd, rm_wr}, 32'd0);
        chk("post rst be_rdata", be_rdata, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
